// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// Rev 1.0 - initial release.
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_MODE_ADD   = 2'd0,
    ALU_MODE_SUB   = 2'd1,
    ALU_MODE_FUNCT = 2'd2
  } alu_mode_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  function automatic logic is_known_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps ALU mode and R-type funct to a zero-extended ALU control code.
// Rev 1.0 - initial release.
`default_nettype none

module mc_alu_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  alu_mode_t              mode,
  input  logic [5:0]             funct,
  output logic [ALUCTRL_W-1:0]   alu_ctrl
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (mode)
      ALU_MODE_SUB: code = ALU_SUB;
      ALU_MODE_FUNCT: begin
        case (funct)
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_ADD;  // unknown funct executes as add
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl = ALUCTRL_W'(code);

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control FSM with memory wait handshake and timeout flag.
// Optional MC_ILLEGAL_TRAP_EN routes unknown opcodes/functs to TRAP. Rev 1.0.
`default_nettype none

module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_W    = 4,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSource,
  output logic                 IRWrite,
  output logic                 MEMWRITE,
  output logic                 RegWrite,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic [3:0]           state_o,
  output logic                 mem_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              waiting;
  alu_mode_t         alu_mode;
  logic              mem_req_raw, ir_write_raw, mem_write_raw, reg_write_raw, pc_en_raw;

  mc_alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
    .mode     (alu_mode),
    .funct    (Funct),
    .alu_ctrl (ALUCtrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (waiting && wait_cnt_next == WAIT_MAX)
        mem_timeout <= 1'b1;
    end
  end

  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state)
      wait_cnt_next = '0;
    else if (waiting && wait_cnt != WAIT_MAX)
      wait_cnt_next = wait_cnt + 1'b1;
  end

  always_comb begin
    state_next    = state;
    mem_req_raw   = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    pc_en_raw     = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    PCSource      = PCSRC_ALU;
    alu_mode      = ALU_MODE_ADD;

    case (state)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SEXT_SH;
        case (Op)
          OP_RTYPE:      state_next = S_EXEC;
          OP_LW, OP_SW:  state_next = S_MEMADR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:       state_next = S_ADDIEX;
          OP_J:          state_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:       state_next = S_TRAP;
`else
          default:       state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
        if (Op == OP_LW)      state_next = S_MEMRD;
        else if (Op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw   = 1'b1;
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        alu_mode   = ALU_MODE_FUNCT;
`ifdef MC_ILLEGAL_TRAP_EN
        state_next = is_known_funct(Funct) ? S_ALUWB : S_TRAP;
`else
        state_next = S_ALUWB;
`endif
      end
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_mode   = ALU_MODE_SUB;
        PCSource   = PCSRC_ALUOUT;
        pc_en_raw  = Op[0] ? ~Zero : Zero;  // bit0 distinguishes bne from beq
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_SEXT;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = PCSRC_JUMP;
        pc_en_raw  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        PCSource   = PCSRC_TRAP;
        pc_en_raw  = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset kills every enable in the same cycle so an aborted write never lands.
  assign mem_req  = mem_req_raw   & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign MEMWRITE = mem_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign PCEn     = pc_en_raw     & ~reset;
  assign state_o  = state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed self-checking bench for mc_control_fsm.
// Rev 1.0 - initial release.
`default_nettype none

module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       mem_req, IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       IRWrite, MEMWRITE, RegWrite, PCEn;
  logic [2:0] ALUCtrl;
  logic [3:0] state_o;
  logic       mem_timeout;

  int n_cmp = 0;
  int n_fail = 0;

  mc_control_fsm #(.ALUCTRL_W(3), .WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .IRWrite(IRWrite), .MEMWRITE(MEMWRITE),
    .RegWrite(RegWrite), .PCEn(PCEn), .ALUCtrl(ALUCtrl), .state_o(state_o),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; Op = 6'b000000; Funct = 6'b100010; Zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    chk("rst_state",    32'(state_o), 0);
    chk("rst_irwrite",  32'(IRWrite), 0);
    chk("rst_pcen",     32'(PCEn), 0);
    chk("rst_memreq",   32'(mem_req), 0);
    chk("rst_timeout",  32'(mem_timeout), 0);

    // R-type sub
    reset = 1'b0; settle();
    chk("f_memreq",  32'(mem_req), 1);
    chk("f_irwrite", 32'(IRWrite), 1);
    chk("f_pcen",    32'(PCEn), 1);
    chk("f_srcb",    32'(ALUSrcB), 1);
    chk("f_aluctrl", 32'(ALUCtrl), 32'b010);
    chk("f_regwr",   32'(RegWrite), 0);
    step();
    chk("r_dec_state", 32'(state_o), 1);
    chk("r_dec_srcb",  32'(ALUSrcB), 3);
    step();
    chk("r_exec_state", 32'(state_o), 6);
    chk("r_exec_alu",   32'(ALUCtrl), 32'b110);
    chk("r_exec_regwr", 32'(RegWrite), 0);
    step();
    chk("r_wb_state",  32'(state_o), 7);
    chk("r_wb_regwr",  32'(RegWrite), 1);
    chk("r_wb_regdst", 32'(RegDst), 1);
    step();
    chk("r_back_state", 32'(state_o), 0);

    // FETCH holds while memory not ready
    mem_ready = 1'b0; settle();
    chk("fh_irwrite", 32'(IRWrite), 0);
    chk("fh_pcen",    32'(PCEn), 0);
    step();
    chk("fh_state", 32'(state_o), 0);
    mem_ready = 1'b1;

    // lw with 3 wait cycles in MEMRD
    Op = 6'b100011;
    step(); step();
    chk("lw_adr_state", 32'(state_o), 2);
    chk("lw_adr_srcb",  32'(ALUSrcB), 2);
    chk("lw_adr_srca",  32'(ALUSrcA), 1);
    mem_ready = 1'b0;
    step();
    chk("lw_rd_state", 32'(state_o), 3);
    step(); step(); step();
    chk("lw_hold_state", 32'(state_o), 3);
    chk("lw_hold_iord",  32'(IorD), 1);
    chk("lw_hold_req",   32'(mem_req), 1);
    mem_ready = 1'b1;
    step();
    chk("lw_wb_state",  32'(state_o), 4);
    chk("lw_wb_m2r",    32'(MemtoReg), 1);
    chk("lw_wb_regwr",  32'(RegWrite), 1);
    step();
    chk("lw_back_state", 32'(state_o), 0);

    // bne, Zero=0 then Zero=1
    Op = 6'b000101; Zero = 1'b0;
    step(); step();
    chk("bne0_state", 32'(state_o), 8);
    chk("bne0_pcen",  32'(PCEn), 1);
    chk("bne0_pcsrc", 32'(PCSource), 1);
    chk("bne0_alu",   32'(ALUCtrl), 32'b110);
    step();
    Zero = 1'b1;
    step(); step();
    chk("bne1_state", 32'(state_o), 8);
    chk("bne1_pcen",  32'(PCEn), 0);
    step();
    // beq with Zero=1 takes the branch
    Op = 6'b000100;
    step(); step();
    chk("beq1_pcen", 32'(PCEn), 1);
    step();
    Zero = 1'b0;

    // sw with memory stuck: timeout after 15 wait cycles
    Op = 6'b101011;
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("sw_state", 32'(state_o), 5);
    chk("sw_memwr", 32'(MEMWRITE), 1);
    for (int i = 0; i < 14; i++) step();
    chk("sw_to_before", 32'(mem_timeout), 0);
    step();
    chk("sw_to_after", 32'(mem_timeout), 1);
    for (int i = 0; i < 5; i++) step();
    chk("sw_hold_state", 32'(state_o), 5);
    chk("sw_hold_memwr", 32'(MEMWRITE), 1);
    chk("sw_to_sticky",  32'(mem_timeout), 1);
    reset = 1'b1; settle();
    chk("sw_abort_memwr", 32'(MEMWRITE), 0);
    step();
    chk("sw_rst_state",   32'(state_o), 0);
    chk("sw_rst_timeout", 32'(mem_timeout), 0);
    reset = 1'b0; mem_ready = 1'b1;

    // j: 3 cycles back to FETCH
    Op = 6'b000010; settle();
    step(); step();
    chk("j_state", 32'(state_o), 11);
    chk("j_pcen",  32'(PCEn), 1);
    chk("j_pcsrc", 32'(PCSource), 2);
    step();
    chk("j_back_state", 32'(state_o), 0);

    // addi
    Op = 6'b001000;
    step(); step();
    chk("addi_ex_state", 32'(state_o), 9);
    chk("addi_ex_srcb",  32'(ALUSrcB), 2);
    step();
    chk("addi_wb_state", 32'(state_o), 10);
    chk("addi_wb_regwr", 32'(RegWrite), 1);
    chk("addi_wb_regdst", 32'(RegDst), 0);
    step();

    // illegal opcode
    Op = 6'b111111;
    step(); step();
`ifdef MC_ILLEGAL_TRAP_EN
    chk("ill_state", 32'(state_o), 12);
    chk("ill_pcsrc", 32'(PCSource), 3);
    chk("ill_pcen",  32'(PCEn), 1);
    step();
    chk("ill_back_state", 32'(state_o), 0);
`else
    chk("ill_state", 32'(state_o), 0);
    chk("ill_regwr", 32'(RegWrite), 0);
`endif

    // unknown funct
    Op = 6'b000000; Funct = 6'b111111;
`ifdef MC_ILLEGAL_TRAP_EN
    step(); step();
    step();
    chk("uf_state", 32'(state_o), 12);
`else
    step(); step();
    chk("uf_exec_alu", 32'(ALUCtrl), 32'b010);
    step();
    chk("uf_wb_state", 32'(state_o), 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
